// File: rtl/lif_tdm_pkg.sv
// Shared constants for the time-multiplexed LIF scheduler: FSM encoding,
// default neuron constants and the index-width helper.
package lif_tdm_pkg;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FETCH   = 2'd1;
    localparam logic [1:0] S_COMPUTE = 2'd2;
    localparam logic [1:0] S_COMMIT  = 2'd3;

    localparam int DEF_THRESHOLD  = 128;
    localparam int DEF_LEAK_SHIFT = 1;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lif_tdm_scheduler_if.sv
// Bundle of current-request, commit and frame-status signals around the scheduler.
// master = scheduler side, slave = current source / output mux side.
interface lif_tdm_scheduler_if #(
    parameter int N_NEURONS = 5,
    parameter int WIDTH     = 8
);
    import lif_tdm_pkg::*;

    localparam int IW = idx_width(N_NEURONS);

    logic                 start;
    logic [WIDTH-1:0]     cur_in;
    logic [IW-1:0]        cur_idx;
    logic                 cur_req;
    logic [WIDTH-1:0]     state_out;
    logic [IW-1:0]        state_idx;
    logic                 state_valid;
    logic                 spike_out;
    logic [N_NEURONS-1:0] spike_vec;
    logic                 busy;
    logic                 frame_done;

    modport master (
        input  start, cur_in,
        output cur_idx, cur_req, state_out, state_idx, state_valid,
               spike_out, spike_vec, busy, frame_done
    );

    modport slave (
        output start, cur_in,
        input  cur_idx, cur_req, state_out, state_idx, state_valid,
               spike_out, spike_vec, busy, frame_done
    );

endinterface

// File: rtl/lif_update_unit.sv
// Combinational leaky-integrate step: leak, saturating add, threshold compare.
// hold zeroes the input current and masks the spike (refractory neurons).
module lif_update_unit #(
    parameter int WIDTH      = 8,
    parameter int THRESHOLD  = 128,
    parameter int LEAK_SHIFT = 1
) (
    input  logic [WIDTH-1:0] mem,
    input  logic [WIDTH-1:0] cur,
    input  logic             hold,
    output logic [WIDTH-1:0] sum,
    output logic             spike
);
    logic [WIDTH-1:0] leak;
    logic [WIDTH-1:0] cur_g;
    logic [WIDTH:0]   wide;

    always_comb begin
        leak  = mem - (mem >> LEAK_SHIFT);
        cur_g = hold ? '0 : cur;
        wide  = {1'b0, leak} + {1'b0, cur_g};
        sum   = wide[WIDTH] ? {WIDTH{1'b1}} : wide[WIDTH-1:0];
        spike = !hold && ({1'b0, sum} >= (WIDTH+1)'(THRESHOLD));
    end

endmodule

// File: rtl/lif_tdm_scheduler.sv
// Frame scheduler sharing one LIF update datapath across N_NEURONS neurons.
// Optional refractory counters are enabled with `define LIF_TDM_REFRACTORY_EN.
module lif_tdm_scheduler
    import lif_tdm_pkg::*;
#(
    parameter int N_NEURONS     = 5,
    parameter int WIDTH         = 8,
    parameter int THRESHOLD     = DEF_THRESHOLD,
    parameter int LEAK_SHIFT    = DEF_LEAK_SHIFT,
    parameter int REFRAC_FRAMES = 2
) (
    input  logic clk,
    input  logic rst,
    lif_tdm_scheduler_if.master bus
);
    localparam int IW = idx_width(N_NEURONS);

    if (N_NEURONS < 2 || N_NEURONS > 16 || REFRAC_FRAMES < 1) begin : g_bad_param
        $error("lif_tdm_scheduler: unsupported N_NEURONS or REFRAC_FRAMES");
    end

    logic [1:0]           state;
    logic [IW-1:0]        idx;
    logic [WIDTH-1:0]     mem [N_NEURONS];
    logic [WIDTH-1:0]     mem_cur;
    logic [WIDTH-1:0]     cur_r;
    logic [WIDTH-1:0]     sum_r;
    logic                 spk_r;
    logic [WIDTH-1:0]     sum_c;
    logic                 spk_c;
    logic                 hold;
    logic [N_NEURONS-1:0] shadow;
    logic [N_NEURONS-1:0] shadow_next;
    logic [N_NEURONS-1:0] spike_vec_r;
    logic                 frame_done_r;
    logic                 last;

    assign last = (idx == IW'(N_NEURONS - 1));

    always_comb begin
        mem_cur     = '0;
        shadow_next = shadow;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (idx == IW'(i)) begin
                mem_cur        = mem[i];
                shadow_next[i] = spk_r;
            end
        end
    end

`ifdef LIF_TDM_REFRACTORY_EN
    localparam int RW = $clog2(REFRAC_FRAMES + 1);
    logic [RW-1:0] ref_cnt [N_NEURONS];
    logic [RW-1:0] ref_cur;

    always_comb begin
        ref_cur = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (idx == IW'(i)) ref_cur = ref_cnt[i];
        end
    end

    assign hold = (ref_cur != '0);

    // A spike reloads the counter; quiet refractory frames count it down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) ref_cnt[i] <= '0;
        end else if (state == S_COMMIT) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                if (idx == IW'(i)) begin
                    if (spk_r)               ref_cnt[i] <= RW'(REFRAC_FRAMES);
                    else if (ref_cnt[i] != 0) ref_cnt[i] <= ref_cnt[i] - 1'b1;
                end
            end
        end
    end
`else
    assign hold = 1'b0;
`endif

    lif_update_unit #(
        .WIDTH      (WIDTH),
        .THRESHOLD  (THRESHOLD),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_update (
        .mem   (mem_cur),
        .cur   (cur_r),
        .hold  (hold),
        .sum   (sum_c),
        .spike (spk_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            cur_r        <= '0;
            sum_r        <= '0;
            spk_r        <= 1'b0;
            shadow       <= '0;
            spike_vec_r  <= '0;
            frame_done_r <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) mem[i] <= '0;
        end else begin
            frame_done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) state <= S_FETCH;
                end
                S_FETCH: begin
                    cur_r <= bus.cur_in;
                    state <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    sum_r <= sum_c;
                    spk_r <= spk_c;
                    state <= S_COMMIT;
                end
                default: begin
                    for (int i = 0; i < N_NEURONS; i++) begin
                        if (idx == IW'(i)) mem[i] <= spk_r ? '0 : sum_r;
                    end
                    shadow <= shadow_next;
                    if (last) begin
                        // spike_vec and frame_done appear together in the first IDLE cycle.
                        state        <= S_IDLE;
                        idx          <= '0;
                        frame_done_r <= 1'b1;
                        spike_vec_r  <= shadow_next;
                    end else begin
                        state <= S_FETCH;
                        idx   <= idx + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.cur_req     = (state == S_FETCH);
    assign bus.cur_idx     = idx;
    assign bus.state_valid = (state == S_COMMIT);
    assign bus.state_out   = (state == S_COMMIT && !spk_r) ? sum_r : '0;
    assign bus.state_idx   = idx;
    assign bus.spike_out   = (state == S_COMMIT) && spk_r;
    assign bus.spike_vec   = spike_vec_r;
    assign bus.busy        = (state != S_IDLE);
    assign bus.frame_done  = frame_done_r;

endmodule
